sa_output_drain: RTL and testbench
==================================

Name: sa_output_drain

Overview:
Reader at the far end of the output memory that the systolic-array controller writes.
- On i_start, sequentially reads rows 0..N-1 of the output memory through its read port.
- Streams each row out on a valid/ready interface toward the host/DMA side.
- Pulses o_done when the last row has been accepted.
- Sits beside the matmul top; shares the output memory port through an external mux, selected by o_busy.

Parameters:
DATA_WIDTH, 64, width of one output-memory row (ADD_DATAWIDTH*NUM_COLS at the top level)
MEM_ROWS, 8, number of output-memory entries
ADDR_WIDTH, $clog2(MEM_ROWS), memory address width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
i_start  input  1  single-cycle start request; sampled only in IDLE
i_rows  input  ADDR_WIDTH+1  rows to drain; sampled with i_start
o_busy  output  1  high from the cycle after accepted start through the o_done cycle
o_done  output  1  single-cycle completion pulse
o_mem_cenb  output  1  memory chip enable, active low
o_mem_wenb  output  1  memory write enable, active low; tied 1 (read only)
o_mem_addr  output  ADDR_WIDTH  read address
i_mem_data  input  DATA_WIDTH  read data, valid the cycle after a read is issued (cenb=0)
o_valid  output  1  stream data valid
i_ready  input  1  stream consumer ready
o_data  output  DATA_WIDTH  row data
o_last  output  1  marks final row of the drain

Behaviour:
- Reset values: o_busy=0, o_done=0, o_mem_cenb=1, o_mem_wenb=1, o_mem_addr=0, o_valid=0, o_data=0, o_last=0. FIFO empty, state IDLE.
- FSM states:
  - IDLE: i_start=1 with i_rows=0 -> DONE. i_start=1 with i_rows>0 -> DRAIN.
  - DRAIN: issue reads. After the read of row N-1 is issued -> FLUSH.
  - FLUSH: wait until the last beat is accepted (o_valid&&i_ready&&o_last), then -> DONE.
  - DONE: o_done=1 for exactly one cycle, then -> IDLE.
- Row count:
  - i_rows > MEM_ROWS is clamped to MEM_ROWS.
  - Latched count N and read/response counters are held internally.
- Read issue:
  - In DRAIN, o_mem_cenb=0 when credit allows; addr increments 0,1,..,N-1 with no wrap.
  - Credit rule: FIFO occupancy + reads in flight (max 1) <= 2. This never overflows the 2-entry buffer under any backpressure.
- Response: i_mem_data is pushed into the 2-entry FIFO on the cycle after each issued read.
- Stream:
  - o_valid = FIFO not empty; o_data and o_last come from the FIFO head.
  - Once o_valid=1, o_data/o_last stay stable until the handshake.
  - o_valid never drops without a handshake.
  - Push and pop in the same cycle are allowed.
- Throughput: 1 row/cycle with i_ready held high.
- Latency:
  - Start accepted at cycle 0 -> first read at cycle 1 -> first o_valid at cycle 3.
  - o_done is high the cycle after the last handshake.
- o_last is set on the FIFO entry holding row N-1 only.
- i_start while not IDLE is ignored. i_rows is not re-sampled.
- Reset mid-operation: everything returns to reset values immediately (async). Pending rows are discarded; no o_done.

Optional Feature:
SA_DRAIN_ROW_IDX_EN
- Defined: adds output o_row_idx [ADDR_WIDTH-1:0], carried through the FIFO with each row. It equals the memory address the row was read from and is stable under the same rules as o_data; reset value 0.
- Undefined: the port and its FIFO storage do not exist. All other behaviour is identical.

Decomposition:
- sa_pkg holds:
  - typedef enum drain_state_t {IDLE, DRAIN, FLUSH, DONE}
  - localparam SA_DRAIN_FIFO_DEPTH = 2
- One sub-module, sa_skid_fifo: 2-entry register FIFO with push/pop/full/empty, parameterised on payload width. The payload is data+last(+row_idx).

Test Plan:
- i_rows=8, i_ready=1, mem[k]=k+0x100, start at cycle 0:
  - o_data 0x100..0x107 on cycles 3..10, o_last at cycle 10, o_done at cycle 11.
  - o_busy high on cycles 1..11.
- i_rows=8, i_ready low on cycles 4..7:
  - o_data=0x101 held stable through cycle 7.
  - No more than 2 rows buffered plus in flight.
  - All 8 rows arrive in order, no duplicates; o_done the cycle after the row-7 handshake.
- i_rows=0:
  - No o_mem_cenb=0 ever; o_valid stays 0; o_done at cycle 1.
- i_rows=12:
  - Exactly 8 reads issued (addr 0..7); o_last on row 7.
- i_start pulsed again at cycle 5 during the drain:
  - Ignored: exactly one o_done and 8 rows total.
- rst_n asserted at cycle 6 mid-drain:
  - All outputs return to reset values that cycle.
  - A fresh start with i_rows=3 then drains rows 0..2 correctly.

Source files
------------

// File: rtl/sa_output_drain_pkg.sv
// sa_pkg: shared types and constants for the output-memory drain.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        DONE
    } drain_state_t;

    localparam int SA_DRAIN_FIFO_DEPTH = 2;

endpackage

// File: rtl/sa_output_drain_if.sv
// sa_output_drain_if: output-memory read port plus the row stream toward the host/DMA.
// o_row_idx exists only when SA_DRAIN_ROW_IDX_EN is defined.
interface sa_output_drain_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
);
    logic                  o_mem_cenb;
    logic                  o_mem_wenb;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] i_mem_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_last;
`ifdef SA_DRAIN_ROW_IDX_EN
    logic [ADDR_WIDTH-1:0] o_row_idx;

    modport master (
        output o_mem_cenb, o_mem_wenb, o_mem_addr, o_valid, o_data, o_last, o_row_idx,
        input  i_mem_data, i_ready
    );
    modport slave (
        input  o_mem_cenb, o_mem_wenb, o_mem_addr, o_valid, o_data, o_last, o_row_idx,
        output i_mem_data, i_ready
    );
`else
    modport master (
        output o_mem_cenb, o_mem_wenb, o_mem_addr, o_valid, o_data, o_last,
        input  i_mem_data, i_ready
    );
    modport slave (
        input  o_mem_cenb, o_mem_wenb, o_mem_addr, o_valid, o_data, o_last,
        output i_mem_data, i_ready
    );
`endif
endinterface

// File: rtl/sa_output_drain_skid_fifo.sv
// sa_skid_fifo: 2-entry register FIFO; head is presented combinationally and held until popped.
module sa_skid_fifo
    import sa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [SA_DRAIN_FIFO_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;

    // Single-bit pointers are sufficient for the fixed depth of two.
    always_comb begin
        cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SA_DRAIN_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/sa_output_drain.sv
// sa_output_drain: reads output-memory rows 0..N-1 and streams them on valid/ready.
// Define SA_DRAIN_ROW_IDX_EN to carry each row's source address out on o_row_idx.
module sa_output_drain
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MEM_ROWS   = 8,
    parameter int ADDR_WIDTH = $clog2(MEM_ROWS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [ADDR_WIDTH:0] i_rows,
    output logic                o_busy,
    output logic                o_done,
    sa_output_drain_if.master   bus
);
    localparam logic [ADDR_WIDTH:0] MAX_ROWS = (ADDR_WIDTH + 1)'(MEM_ROWS);
`ifdef SA_DRAIN_ROW_IDX_EN
    localparam int PAYLOAD_W = DATA_WIDTH + 1 + ADDR_WIDTH;
`else
    localparam int PAYLOAD_W = DATA_WIDTH + 1;
`endif

    drain_state_t          state_q, state_d;
    logic [ADDR_WIDTH:0]   rows_q, rows_d;
    logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH:0]   rsp_cnt_q, rsp_cnt_d;
    logic                  inflight_q;
    logic [ADDR_WIDTH:0]   start_rows;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  push_last;
    logic                  head_last;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            occ;
    logic [2:0]            load;
    logic [PAYLOAD_W-1:0]  push_payload;
    logic [PAYLOAD_W-1:0]  head_payload;

    assign start_rows = (i_rows > MAX_ROWS) ? MAX_ROWS : i_rows;
    assign push       = inflight_q;
    assign pop        = bus.o_valid && bus.i_ready;
    assign push_last  = (rsp_cnt_q == rows_q - 1'b1);

    // A read may issue only if its data is guaranteed a slot even when nothing
    // drains next cycle; counting this cycle's pop keeps 1 row/cycle at full rate.
    assign occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign load = 3'(occ) + 3'(inflight_q) - 3'(pop);

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        rd_cnt_d  = rd_cnt_q;
        rsp_cnt_d = push ? rsp_cnt_q + 1'b1 : rsp_cnt_q;
        issue     = 1'b0;
        o_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    rows_d    = start_rows;
                    rd_cnt_d  = '0;
                    rsp_cnt_d = '0;
                    state_d   = (start_rows == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (load <= 3'd1) begin
                    issue    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == rows_q - 1'b1) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (pop && head_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            rd_cnt_q   <= '0;
            rsp_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            rd_cnt_q   <= rd_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            inflight_q <= issue;
        end
    end

`ifdef SA_DRAIN_ROW_IDX_EN
    assign push_payload = {bus.i_mem_data, push_last, rsp_cnt_q[ADDR_WIDTH-1:0]};
    assign {bus.o_data, head_last, bus.o_row_idx} = head_payload;
`else
    assign push_payload = {bus.i_mem_data, push_last};
    assign {bus.o_data, head_last} = head_payload;
`endif

    sa_skid_fifo #(
        .WIDTH(PAYLOAD_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .data_i (push_payload),
        .data_o (head_payload),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign o_busy         = (state_q != IDLE);
    assign bus.o_mem_cenb = ~issue;
    assign bus.o_mem_wenb = 1'b1;
    assign bus.o_mem_addr = rd_cnt_q[ADDR_WIDTH-1:0];
    assign bus.o_valid    = ~fifo_empty;
    assign bus.o_last     = head_last;

endmodule

// File: tb/tb_sa_output_drain.sv
// tb_sa_output_drain: directed checks of the output drain against hand-derived cycle timelines.
module tb_sa_output_drain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [3:0] i_rows;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int errors = 0;

    sa_output_drain_if #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) bus ();

    sa_output_drain #(
        .DATA_WIDTH(64),
        .MEM_ROWS  (8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(i_start),
        .i_rows (i_rows),
        .o_busy (o_busy),
        .o_done (o_done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: mem[k] = 0x100 + k, data valid the cycle after cenb=0.
    always @(posedge clk) begin
        if (!bus.o_mem_cenb) bus.i_mem_data <= 64'h100 + 64'(bus.o_mem_addr);
    end

    logic        s_busy, s_done, s_cenb, s_valid, s_last;
    logic [2:0]  s_addr;
    logic [63:0] s_data;
    logic [63:0] rx[$];
    logic [2:0]  addr_q[$];
    int          done_cnt, last_cnt, rd_cnt, hs_cnt, max_out;
    logic [63:0] last_data;

    task automatic clear_log();
        rx.delete();
        addr_q.delete();
        done_cnt = 0; last_cnt = 0; rd_cnt = 0; hs_cnt = 0; max_out = 0;
        last_data = '0;
    endtask

    // One cycle: drive inputs for this cycle at negedge, then sample outputs.
    task automatic tick(input logic st, input logic [3:0] rows, input logic rdy);
        @(negedge clk);
        i_start = st;
        i_rows = rows;
        bus.i_ready = rdy;
        #1;
        s_busy = o_busy; s_done = o_done; s_cenb = bus.o_mem_cenb; s_addr = bus.o_mem_addr;
        s_valid = bus.o_valid; s_data = bus.o_data; s_last = bus.o_last;
        if (rd_cnt - hs_cnt > max_out) max_out = rd_cnt - hs_cnt;
        if (!s_cenb) begin
            addr_q.push_back(s_addr);
            rd_cnt++;
        end
        if (s_valid && rdy) begin
            rx.push_back(s_data);
            hs_cnt++;
            if (s_last) begin
                last_cnt++;
                last_data = s_data;
            end
        end
        if (s_done) done_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_rows = '0; bus.i_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h want 0", o_done); end
        checks++; if (bus.o_mem_cenb !== 1'b1) begin errors++; $display("FAIL reset_cenb got %0h want 1", bus.o_mem_cenb); end
        checks++; if (bus.o_mem_wenb !== 1'b1) begin errors++; $display("FAIL reset_wenb got %0h want 1", bus.o_mem_wenb); end
        checks++; if (bus.o_mem_addr !== 3'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", bus.o_mem_addr); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", bus.o_valid); end
        checks++; if (bus.o_data !== 64'h0) begin errors++; $display("FAIL reset_data got %0h want 0", bus.o_data); end
        checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0h want 0", bus.o_last); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_rate();
        logic ev, ec;
        clear_log();
        for (int c = 0; c <= 12; c++) begin
            tick(c == 0, 4'd8, 1'b1);
            ev = (c >= 3 && c <= 10);
            ec = (c >= 1 && c <= 8);
            checks++; if (s_valid !== ev) begin errors++; $display("FAIL full_valid c%0d got %0h want %0h", c, s_valid, ev); end
            checks++; if (s_busy !== (c >= 1 && c <= 11)) begin errors++; $display("FAIL full_busy c%0d got %0h want %0h", c, s_busy, (c >= 1 && c <= 11)); end
            checks++; if (s_done !== (c == 11)) begin errors++; $display("FAIL full_done c%0d got %0h want %0h", c, s_done, (c == 11)); end
            checks++; if (s_cenb !== !ec) begin errors++; $display("FAIL full_cenb c%0d got %0h want %0h", c, s_cenb, !ec); end
            if (ec) begin
                checks++; if (s_addr !== 3'(c - 1)) begin errors++; $display("FAIL full_addr c%0d got %0h want %0h", c, s_addr, c - 1); end
            end
            if (ev) begin
                checks++; if (s_data !== 64'h100 + 64'(c - 3)) begin errors++; $display("FAIL full_data c%0d got %0h want %0h", c, s_data, 64'h100 + 64'(c - 3)); end
                checks++; if (s_last !== (c == 10)) begin errors++; $display("FAIL full_last c%0d got %0h want %0h", c, s_last, (c == 10)); end
            end
        end
        checks++; if (bus.o_mem_wenb !== 1'b1) begin errors++; $display("FAIL full_wenb got %0h want 1", bus.o_mem_wenb); end
    endtask

    task automatic test_backpressure();
        logic        ev;
        logic [63:0] ed;
        clear_log();
        for (int c = 0; c <= 16; c++) begin
            tick(c == 0, 4'd8, !(c >= 4 && c <= 7));
            ev = (c >= 3 && c <= 14);
            ed = (c <= 3) ? 64'h100 : (c <= 8) ? 64'h101 : 64'h100 + 64'(c - 7);
            checks++; if (s_valid !== ev) begin errors++; $display("FAIL bp_valid c%0d got %0h want %0h", c, s_valid, ev); end
            if (ev) begin
                checks++; if (s_data !== ed) begin errors++; $display("FAIL bp_data c%0d got %0h want %0h", c, s_data, ed); end
            end
            checks++; if (s_done !== (c == 15)) begin errors++; $display("FAIL bp_done c%0d got %0h want %0h", c, s_done, (c == 15)); end
        end
        checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding got %0d want <=2", max_out); end
        checks++; if (rx.size() != 8) begin errors++; $display("FAIL bp_rows got %0d want 8", rx.size()); end
        for (int i = 0; i < rx.size(); i++) begin
            checks++; if (rx[i] !== 64'h100 + 64'(i)) begin errors++; $display("FAIL bp_order i%0d got %0h want %0h", i, rx[i], 64'h100 + 64'(i)); end
        end
    endtask

    task automatic test_zero_rows();
        clear_log();
        for (int c = 0; c <= 4; c++) begin
            tick(c == 0, 4'd0, 1'b1);
            checks++; if (s_cenb !== 1'b1) begin errors++; $display("FAIL zero_cenb c%0d got %0h want 1", c, s_cenb); end
            checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL zero_valid c%0d got %0h want 0", c, s_valid); end
            checks++; if (s_done !== (c == 1)) begin errors++; $display("FAIL zero_done c%0d got %0h want %0h", c, s_done, (c == 1)); end
        end
    endtask

    task automatic test_clamp();
        clear_log();
        for (int c = 0; c <= 12; c++) tick(c == 0, 4'd12, 1'b1);
        checks++; if (addr_q.size() != 8) begin errors++; $display("FAIL clamp_reads got %0d want 8", addr_q.size()); end
        for (int i = 0; i < addr_q.size(); i++) begin
            checks++; if (addr_q[i] !== 3'(i)) begin errors++; $display("FAIL clamp_addr i%0d got %0h want %0h", i, addr_q[i], i); end
        end
        checks++; if (last_cnt != 1) begin errors++; $display("FAIL clamp_last_cnt got %0d want 1", last_cnt); end
        checks++; if (last_data !== 64'h107) begin errors++; $display("FAIL clamp_last_row got %0h want 107", last_data); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL clamp_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_restart_ignored();
        clear_log();
        for (int c = 0; c <= 13; c++) tick(c == 0 || c == 5, (c == 5) ? 4'd2 : 4'd8, 1'b1);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_cnt got %0d want 1", done_cnt); end
        checks++; if (rx.size() != 8) begin errors++; $display("FAIL restart_rows got %0d want 8", rx.size()); end
        if (rx.size() == 8) begin
            checks++; if (rx[7] !== 64'h107) begin errors++; $display("FAIL restart_row7 got %0h want 107", rx[7]); end
        end
    endtask

    task automatic test_reset_mid_drain();
        clear_log();
        for (int c = 0; c <= 5; c++) tick(c == 0, 4'd8, 1'b1);
        @(negedge clk);
        i_start = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0h want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL mid_done got %0h want 0", o_done); end
        checks++; if (bus.o_mem_cenb !== 1'b1) begin errors++; $display("FAIL mid_cenb got %0h want 1", bus.o_mem_cenb); end
        checks++; if (bus.o_mem_addr !== 3'd0) begin errors++; $display("FAIL mid_addr got %0h want 0", bus.o_mem_addr); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0h want 0", bus.o_valid); end
        checks++; if (bus.o_data !== 64'h0) begin errors++; $display("FAIL mid_data got %0h want 0", bus.o_data); end
        checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL mid_last got %0h want 0", bus.o_last); end
        clear_log();
        repeat (2) tick(1'b0, 4'd0, 1'b1);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 4'd0, 1'b1);
        checks++; if (done_cnt != 0 || rd_cnt != 0 || hs_cnt != 0) begin errors++; $display("FAIL mid_quiet got done%0d rd%0d hs%0d want 0 0 0", done_cnt, rd_cnt, hs_cnt); end
        clear_log();
        for (int c = 0; c <= 8; c++) begin
            tick(c == 0, 4'd3, 1'b1);
            checks++; if (s_valid !== (c >= 3 && c <= 5)) begin errors++; $display("FAIL fresh_valid c%0d got %0h want %0h", c, s_valid, (c >= 3 && c <= 5)); end
            if (c >= 3 && c <= 5) begin
                checks++; if (s_data !== 64'h100 + 64'(c - 3)) begin errors++; $display("FAIL fresh_data c%0d got %0h want %0h", c, s_data, 64'h100 + 64'(c - 3)); end
                checks++; if (s_last !== (c == 5)) begin errors++; $display("FAIL fresh_last c%0d got %0h want %0h", c, s_last, (c == 5)); end
            end
            checks++; if (s_done !== (c == 6)) begin errors++; $display("FAIL fresh_done c%0d got %0h want %0h", c, s_done, (c == 6)); end
        end
        checks++; if (rx.size() != 3) begin errors++; $display("FAIL fresh_rows got %0d want 3", rx.size()); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_zero_rows();
        test_clamp();
        test_restart_ignored();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
